merge_sorted_streams: RTL and testbench

MERGE_SORTED_STREAMS -- requirements
Module: merge_sorted_streams

---
 rtl/bwt_pkg.sv | 16 +
 rtl/sym_compare.sv | 22 ++
 rtl/merge_sorted_streams.sv | 138 +++++++++++++
 tb/tb_merge_sorted_streams.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT sort blocks:
// merge FSM state encoding and compare-direction constants.
package bwt_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MERGE   = 3'd1;
  localparam logic [2:0] S_DRAIN_L = 3'd2;
  localparam logic [2:0] S_DRAIN_R = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam int ORDER_ASC  = 0;
  localparam int ORDER_DESC = 1;

endpackage

// File: rtl/sym_compare.sv
// Unsigned symbol compare for the merge; equal symbols
// favour the left side so the merge stays stable.
module sym_compare
  import bwt_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int DESCEND = ORDER_ASC
) (
  input  logic [SYM_W-1:0] l_sym,
  input  logic [SYM_W-1:0] r_sym,
  output logic             take_left
);

  generate
    if (DESCEND == ORDER_DESC) begin : g_desc
      assign take_left = (l_sym >= r_sym);
    end else begin : g_asc
      assign take_left = (l_sym <= r_sym);
    end
  endgenerate

endmodule

// File: rtl/merge_sorted_streams.sv
// Two-way merge of sorted symbol streams into one
// registered output stream with last/done signalling.
module merge_sorted_streams
  import bwt_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int LEN_W   = 8,
  parameter int DESCEND = ORDER_ASC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_l,
  input  logic [LEN_W-1:0] len_r,
  input  logic [SYM_W-1:0] l_data,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [SYM_W-1:0] r_data,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [LEN_W-1:0] rem_l;
  logic [LEN_W-1:0] rem_r;
  logic             slot_free;
  logic             take_left;
  logic             pick_l;
  logic             pick_r;
  logic [LEN_W:0]   rem_sum;
  logic             last_beat;

  sym_compare #(
    .SYM_W  (SYM_W),
    .DESCEND(DESCEND)
  ) u_cmp (
    .l_sym    (l_data),
    .r_sym    (r_data),
    .take_left(take_left)
  );

  assign slot_free = !out_valid || out_ready;
  assign rem_sum   = {1'b0, rem_l} + {1'b0, rem_r};
  assign last_beat = (rem_sum == (LEN_W+1)'(1));

  // Input readies are combinational so the chosen
  // element moves into the output register this edge.
  always_comb begin
    pick_l = 1'b0;
    pick_r = 1'b0;
    unique case (1'b1)
      (state == S_MERGE): begin
        if (l_valid && r_valid && slot_free) begin
          pick_l = take_left;
          pick_r = !take_left;
        end
      end
      (state == S_DRAIN_L): pick_l = l_valid && slot_free;
      (state == S_DRAIN_R): pick_r = r_valid && slot_free;
      default: ;
    endcase
  end

  assign l_ready = pick_l;
  assign r_ready = pick_r;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rem_l     <= '0;
      rem_r     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (pick_l || pick_r) begin
        out_data  <= pick_l ? l_data : r_data;
        out_valid <= 1'b1;
        out_last  <= last_beat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (pick_l) rem_l <= rem_l - LEN_W'(1);
      if (pick_r) rem_r <= rem_r - LEN_W'(1);

      unique case (1'b1)
        (state == S_IDLE): begin
          if (start) begin
            rem_l <= len_l;
            rem_r <= len_r;
            if (len_l != '0 && len_r != '0)
              state <= S_MERGE;
            else if (len_l != '0)
              state <= S_DRAIN_L;
            else if (len_r != '0)
              state <= S_DRAIN_R;
            else
              state <= S_FINISH;
          end
        end
        (state == S_MERGE): begin
          if (pick_l && rem_l == LEN_W'(1))
            state <= S_DRAIN_R;
          else if (pick_r && rem_r == LEN_W'(1))
            state <= S_DRAIN_L;
        end
        (state == S_DRAIN_L): begin
          if (pick_l && rem_l == LEN_W'(1))
            state <= S_FINISH;
        end
        (state == S_DRAIN_R): begin
          if (pick_r && rem_r == LEN_W'(1))
            state <= S_FINISH;
        end
        (state == S_FINISH): begin
          // Hold one extra cycle so done is seen while busy.
          if (done)
            state <= S_IDLE;
          else if (!out_valid)
            done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_sorted_streams.sv
// Randomized bench: ascending and descending mergers
// checked against a queue-based stable-merge model.
module tb_merge_sorted_streams;

  typedef logic [7:0] sym_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start [2];
  sym_t len_l [2];
  sym_t len_r [2];
  sym_t l_data [2];
  logic l_valid [2];
  logic l_ready [2];
  sym_t r_data [2];
  logic r_valid [2];
  logic r_ready [2];
  sym_t out_data [2];
  logic out_valid [2];
  logic out_ready [2];
  logic out_last [2];
  logic busy [2];
  logic done [2];

  int checks = 0;
  int failures = 0;

  merge_sorted_streams #(.SYM_W(8), .LEN_W(8), .DESCEND(0)) u_asc (
    .clk(clk), .rst(rst), .start(start[0]),
    .len_l(len_l[0]), .len_r(len_r[0]),
    .l_data(l_data[0]), .l_valid(l_valid[0]), .l_ready(l_ready[0]),
    .r_data(r_data[0]), .r_valid(r_valid[0]), .r_ready(r_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_last(out_last[0]),
    .busy(busy[0]), .done(done[0])
  );

  merge_sorted_streams #(.SYM_W(8), .LEN_W(8), .DESCEND(1)) u_desc (
    .clk(clk), .rst(rst), .start(start[1]),
    .len_l(len_l[1]), .len_r(len_r[1]),
    .l_data(l_data[1]), .l_valid(l_valid[1]), .l_ready(l_ready[1]),
    .r_data(r_data[1]), .r_valid(r_valid[1]), .r_ready(r_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_last(out_last[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stable merge: take heads in order, left wins ties; sd 1 = right.
  function automatic void model(input sym_t lq[$], input sym_t rq[$],
                                input int desc, output sym_t oq[$],
                                output bit sd[$]);
    int i = 0;
    int j = 0;
    bit tl;
    oq = {};
    sd = {};
    while (i < lq.size() || j < rq.size()) begin
      if (i >= lq.size()) tl = 1'b0;
      else if (j >= rq.size()) tl = 1'b1;
      else if (desc != 0) tl = (lq[i] >= rq[j]);
      else tl = (lq[i] <= rq[j]);
      if (tl) begin oq.push_back(lq[i]); i++; end
      else begin oq.push_back(rq[j]); j++; end
      sd.push_back(!tl);
    end
  endfunction

  task automatic drive_idle(input int d);
    start[d] = 1'b0;
    len_l[d] = '0;
    len_r[d] = '0;
    l_data[d] = '0;
    r_data[d] = '0;
    l_valid[d] = 1'b0;
    r_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid[d]), 0);
    chk({tag, "_out_data"}, 32'(out_data[d]), 0);
    chk({tag, "_out_last"}, 32'(out_last[d]), 0);
    chk({tag, "_done"}, 32'(done[d]), 0);
    chk({tag, "_busy"}, 32'(busy[d]), 0);
    chk({tag, "_l_ready"}, 32'(l_ready[d]), 0);
    chk({tag, "_r_ready"}, 32'(r_ready[d]), 0);
  endtask

  task automatic run_job(input int d, input sym_t lq[$], input sym_t rq[$],
                         input int p_in, input int p_out,
                         input int stall3, input int abort_after);
    sym_t exp_q[$];
    bit   exp_sd[$];
    int   li = 0, ri = 0, si = 0, got = 0;
    int   busy_cyc = 0, done_cyc = -1, stall = 0, cyc;
    bit   held = 0, fin = 0, abort = 0;
    sym_t hd = '0;
    logic hl = 1'b0;
    model(lq, rq, d, exp_q, exp_sd);

    @(negedge clk);
    drive_idle(d);
    len_l[d] = sym_t'(lq.size());
    len_r[d] = sym_t'(rq.size());
    start[d] = 1'b1;

    for (cyc = 0; cyc < 3000 && !fin && !abort; cyc++) begin
      @(negedge clk);
      start[d] = ($urandom_range(0, 3) == 0);
      len_l[d] = sym_t'($urandom);
      len_r[d] = sym_t'($urandom);
      l_valid[d] = (li < lq.size()) && ($urandom_range(1, 100) <= p_in);
      r_valid[d] = (ri < rq.size()) && ($urandom_range(1, 100) <= p_in);
      l_data[d] = (li < lq.size()) ? lq[li] : sym_t'($urandom);
      r_data[d] = (ri < rq.size()) ? rq[ri] : sym_t'($urandom);
      out_ready[d] = ($urandom_range(1, 100) <= p_out);
      if (stall > 0) begin
        out_ready[d] = 1'b0;
        stall--;
      end
      #1;
      if (busy[d]) busy_cyc++;
      if (held) begin
        chk("hold_valid", 32'(out_valid[d]), 1);
        chk("hold_data", 32'(out_data[d]), 32'(hd));
        chk("hold_last", 32'(out_last[d]), 32'(hl));
      end
      if ((l_ready[d] || r_ready[d]) && out_valid[d] && !out_ready[d])
        chk("ready_slot_full", 1, 0);
      if (l_ready[d] && r_ready[d]) chk("both_ready", 1, 0);
      if (l_ready[d] && li >= lq.size()) chk("l_ready_spent", 1, 0);
      if (r_ready[d] && ri >= rq.size()) chk("r_ready_spent", 1, 0);
      if (l_ready[d] && l_valid[d]) begin
        chk("side_order_l", 32'(exp_sd[si]), 0);
        si++; li++;
      end
      if (r_ready[d] && r_valid[d]) begin
        chk("side_order_r", 32'(exp_sd[si]), 1);
        si++; ri++;
      end
      if (out_valid[d] && got >= exp_q.size()) chk("extra_beat", 1, 0);
      if (out_valid[d] && out_ready[d] && got < exp_q.size()) begin
        chk("out_data", 32'(out_data[d]), 32'(exp_q[got]));
        chk("out_last", 32'(out_last[d]), 32'(got == exp_q.size() - 1));
        got++;
        if (stall3 != 0 && got == 1) stall = 3;
        if (got == abort_after) abort = 1;
      end
      held = out_valid[d] && !out_ready[d];
      hd = out_data[d];
      hl = out_last[d];
      if (done[d]) begin
        chk("done_count", 32'(got), 32'(exp_q.size()));
        done_cyc = cyc;
        fin = 1;
      end
    end

    if (abort) begin
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_zero(d, "mid_rst");
      @(negedge clk);
      drive_idle(d);
      rst = 1'b1;
      return;
    end
    if (!fin) begin
      chk("job_timeout", 1, 0);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("zero_busy_cycles", 32'(busy_cyc), 2);
      chk("zero_done_cycle", 32'(done_cyc), 1);
    end
    @(negedge clk);
    drive_idle(d);
    #1;
    chk("done_pulse_end", 32'(done[d]), 0);
    chk("busy_end", 32'(busy[d]), 0);
    chk("valid_end", 32'(out_valid[d]), 0);
  endtask

  initial begin
    sym_t a[$], b[$], o[$];
    bit sd[$];
    int n;
    rst = 1'b0;
    drive_idle(0);
    drive_idle(1);
    #12;
    chk_zero(0, "reset_asc");
    chk_zero(1, "reset_desc");
    @(negedge clk);
    rst = 1'b1;

    a = '{8'h61, 8'h62};
    b = '{8'h61, 8'h63};
    model(a, b, 0, o, sd);
    chk("model_s1_size", 32'(o.size()), 4);
    chk("model_s1", {o[0], o[1], o[2], o[3]}, 32'h61616263);
    chk("model_s1_sides", {28'd0, sd[0], sd[1], sd[2], sd[3]}, 32'b0101);
    run_job(0, a, b, 100, 100, 0, -1);
    run_job(0, a, b, 100, 100, 1, -1);

    a = {};
    b = '{8'h10, 8'h20, 8'h30};
    run_job(0, a, b, 100, 100, 0, -1);
    b = {};
    run_job(0, a, b, 100, 100, 0, -1);
    run_job(1, a, b, 100, 100, 0, -1);

    a = '{8'h90, 8'h20};
    b = '{8'h50, 8'h50};
    model(a, b, 1, o, sd);
    chk("model_s5", {o[0], o[1], o[2], o[3]}, 32'h90505020);
    run_job(1, a, b, 100, 100, 0, -1);

    a = '{8'h11, 8'h33};
    b = '{8'h22, 8'h44};
    run_job(0, a, b, 100, 100, 0, 2);
    a = '{8'h61, 8'h62};
    b = '{8'h61, 8'h63};
    run_job(0, a, b, 100, 100, 0, -1);

    for (int j = 0; j < 40; j++) begin
      int d;
      d = j % 2;
      a = {};
      b = {};
      n = ($urandom_range(0, 5) == 0) ? 20 : 6;
      n = $urandom_range(0, n);
      for (int k = 0; k < n; k++) a.push_back(sym_t'($urandom_range(0, 15)));
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) b.push_back(sym_t'($urandom_range(0, 15)));
      if (j % 7 != 3) begin
        if (d == 0) begin a.sort(); b.sort(); end
        else begin a.rsort(); b.rsort(); end
      end
      run_job(d, a, b, $urandom_range(30, 100), $urandom_range(30, 100),
              0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
